// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter, one operand
//               bit per clock. Optional leading-zero blank flags are enabled
//               by defining the macro BCD_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   bin,
    output logic           busy,
    output logic           done,
    output logic [4*D-1:0] bcd,
    output logic           ovf
`ifdef BCD_BLANK_EN
    ,
    output logic [D-1:0]   blank
`endif
);

    localparam int              c_cnt_w    = $clog2(W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         shreg_q, shreg_d;
    logic [4*D-1:0]       acc_q,   acc_d;
    logic [c_cnt_w-1:0]   cnt_q,   cnt_d;
    logic                 sticky_q, sticky_d;
    logic [4*D-1:0]       bcd_q,   bcd_d;
    logic                 ovf_q,   ovf_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    // Add-3 correction applied to each digit before the shift.
    logic [4*D-1:0]       w_adj;
    logic [4*D:0]         w_shifted;

    for (genvar i = 0; i < D; i++) begin : g_adj
        logic [3:0] w_dig;
        assign w_dig              = acc_q[4*i +: 4];
        assign w_adj[4*i +: 4]    = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
    end

    // Bit 4*D is the carry out of the top digit; it marks overflow.
    assign w_shifted = {w_adj, shreg_q[W-1]};

`ifdef BCD_BLANK_EN
    logic [D-1:0] blank_q, blank_d;
    logic [D:0]   w_zero_from;
    logic [D-1:0] w_blank_new;

    assign w_zero_from[D] = 1'b1;
    for (genvar i = 0; i < D; i++) begin : g_zero
        assign w_zero_from[i] = w_zero_from[i+1] & (w_shifted[4*i +: 4] == 4'd0);
    end
    // The units digit is never blanked so a zero result still shows "0".
    assign w_blank_new = w_zero_from[D-1:0] & ~(D'(1));
`endif

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
`ifdef BCD_BLANK_EN
        blank_d  = blank_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SHIFT;
                    shreg_d  = bin;
                    acc_d    = '0;
                    cnt_d    = c_cnt_load;
                    sticky_d = 1'b0;
                end
            end
            S_SHIFT: begin
                acc_d    = w_shifted[4*D-1:0];
                shreg_d  = shreg_q << 1;
                cnt_d    = cnt_q - 1'b1;
                sticky_d = sticky_q | w_shifted[4*D];
                if (cnt_d == '0) begin
                    state_d = S_DONE;
                    bcd_d   = w_shifted[4*D-1:0];
                    ovf_d   = sticky_d;
`ifdef BCD_BLANK_EN
                    blank_d = w_blank_new;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q  <= '1;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BCD_BLANK_EN
            blank_q  <= blank_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign ovf   = ovf_q;
`ifdef BCD_BLANK_EN
    assign blank = blank_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq on three configurations
//               (W8/D3, W8/D2, W16/D5) against a decimal reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [7:0]  bin0 = '0, bin1 = '0;
    logic [15:0] bin2 = '0;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [19:0] bcd2;
    logic        ovf0, ovf1, ovf2;
`ifdef BCD_BLANK_EN
    logic [2:0]  blank0;
    logic [1:0]  blank1;
    logic [4:0]  blank2;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [63:0] last_bcd [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.W(8), .D(3)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .bin(bin0),
        .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0)
`ifdef BCD_BLANK_EN
        , .blank(blank0)
`endif
    );

    bin2bcd_seq #(.W(8), .D(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
`ifdef BCD_BLANK_EN
        , .blank(blank1)
`endif
    );

    bin2bcd_seq #(.W(16), .D(5)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
`ifdef BCD_BLANK_EN
        , .blank(blank2)
`endif
    );

    // ---------------- reference model: plain decimal arithmetic ----------------
    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [63:0] ref_bcd(input longint v, input int d);
        logic [63:0] r = '0;
        longint x = v % pow10(d);
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_ovf(input longint v, input int d);
        return (v >= pow10(d)) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] ref_blank(input longint v, input int d);
        logic [63:0] r = '0;
        longint low = v % pow10(d);
        for (int i = 1; i < d; i++)
            if (low / pow10(i) == 0) r[i] = 1'b1;
        return r;
    endfunction

    // ---------------- per-instance access helpers ----------------
    function automatic int w_of(input int sel);
        return (sel == 2) ? 16 : 8;
    endfunction

    function automatic int d_of(input int sel);
        return (sel == 0) ? 3 : ((sel == 1) ? 2 : 5);
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done0 : ((sel == 1) ? done1 : done2);
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : ((sel == 1) ? busy1 : busy2);
    endfunction

    function automatic logic get_ovf(input int sel);
        return (sel == 0) ? ovf0 : ((sel == 1) ? ovf1 : ovf2);
    endfunction

    function automatic logic [63:0] get_bcd(input int sel);
        case (sel)
            0:       return 64'(bcd0);
            1:       return 64'(bcd1);
            default: return 64'(bcd2);
        endcase
    endfunction

    task automatic set_in(input int sel, input logic st, input longint v);
        case (sel)
            0:       begin start0 = st; bin0 = v[7:0];  end
            1:       begin start1 = st; bin1 = v[7:0];  end
            default: begin start2 = st; bin2 = v[15:0]; end
        endcase
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input int sel, input longint v);
        chk("bcd", get_bcd(sel), ref_bcd(v, d_of(sel)));
        chk("ovf", 64'(get_ovf(sel)), ref_ovf(v, d_of(sel)));
`ifdef BCD_BLANK_EN
        if (sel == 0) chk("blank", 64'(blank0), ref_blank(v, 3));
`endif
        last_bcd[sel] = ref_bcd(v, d_of(sel));
    endtask

    // Full handshake: launch, scramble bin after acceptance, time the done pulse.
    task automatic convert(input int sel, input longint v);
        int n = 0;
        set_in(sel, 1'b1, v);
        tick;
        set_in(sel, 1'b0, longint'($urandom));
        chk("busy_accept", 64'(get_busy(sel)), 64'd1);
        while (!get_done(sel) && n < 40) begin
            if (n == 2) chk("bcd_hold_busy", get_bcd(sel), last_bcd[sel]);
            tick;
            n++;
        end
        chk("latency", 64'(n), 64'(w_of(sel)));
        chk("busy_in_done", 64'(get_busy(sel)), 64'd0);
        chk_result(sel, v);
        tick;
        chk("done_pulse", 64'(get_done(sel)), 64'd0);
        chk("bcd_hold_idle", get_bcd(sel), last_bcd[sel]);
    endtask

    initial begin
        int n;
        int last_cyc;
        logic [63:0] keep;
        for (int i = 0; i < 3; i++) last_bcd[i] = '0;

        // Reset state
        tick; tick;
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_bcd",  64'(bcd0),  64'd0);
        chk("rst_ovf",  64'(ovf0),  64'd0);
`ifdef BCD_BLANK_EN
        chk("rst_blank", 64'(blank0), 64'h7);
`endif

        // Start sampled on the first edge after release is accepted
        reset = 1'b0;
        convert(0, 255);
        convert(0, 0);
        convert(0, 7);
        convert(0, 128);
        for (int i = 0; i < 6; i++) convert(0, longint'($urandom_range(255)));

        // Two-digit instance: overflow boundary and mod-100 residue
        convert(1, 100);
        convert(1, 99);
        convert(1, 255);
        for (int i = 0; i < 4; i++) convert(1, longint'($urandom_range(255)));

        // Wide instance with a start pulse during busy that must be ignored
        set_in(2, 1'b1, 65535);
        tick;
        set_in(2, 1'b0, 0);
        tick; tick; tick;
        set_in(2, 1'b1, 1234);
        tick;
        set_in(2, 1'b0, 0);
        n = 4;
        while (!done2 && n < 40) begin tick; n++; end
        chk("w16_latency", 64'(n), 64'd16);
        chk_result(2, 65535);
        n = 0;
        for (int i = 0; i < 25; i++) begin
            tick;
            if (done2) n++;
        end
        chk("w16_no_extra_done", 64'(n), 64'd0);
        chk("w16_result_kept", 64'(bcd2), 64'h65535);
        for (int i = 0; i < 3; i++) convert(2, longint'($urandom_range(65535)));

        // Reset mid-conversion: immediate clear, no done, then a clean restart
        set_in(0, 1'b1, 200);
        tick;
        set_in(0, 1'b0, 0);
        tick; tick; tick;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy0), 64'd0);
        chk("mid_rst_done", 64'(done0), 64'd0);
        chk("mid_rst_bcd",  64'(bcd0),  64'd0);
        chk("mid_rst_ovf",  64'(ovf0),  64'd0);
        for (int i = 0; i < 3; i++) last_bcd[i] = '0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done0) n++;
        end
        chk("mid_rst_no_done", 64'(n), 64'd0);
        reset = 1'b0;
        convert(0, 128);

        // Exhaustive sweep with start held high; bin scrambled while busy
        start0   = 1'b1;
        bin0     = 8'd0;
        last_cyc = 0;
        tick;
        for (int v = 0; v < 256; v++) begin
            bin0 = 8'($urandom);
            n = 0;
            while (!done0 && n < 40) begin tick; n++; end
            if (v > 0) chk("done_spacing", 64'(cyc - last_cyc), 64'd10);
            last_cyc = cyc;
            chk_result(0, longint'(v));
            if (v < 255) begin
                bin0 = 8'(v + 1);
                tick;
                tick;
            end
        end
        start0 = 1'b0;
        keep = last_bcd[0];
        tick; tick; tick;
        chk("final_hold", 64'(bcd0), keep);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
